// File: rtl/uart_pkg.sv
// uart_pkg: shared UART transmit-queue FSM states and data-width default
package uart_pkg;
    localparam int UART_DATA_W = 8;
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} txq_state_e;
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: synchronous FIFO with registered full/empty/count and a combinational read port
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = UART_DATA_W
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic full_q, full_d, empty_q, empty_d, do_push, do_pop;
    // Pushes are gated by the registered full flag, so a pop on the same edge cannot make room
    always_comb begin
        do_push  = push && !full_q;
        do_pop   = pop && !empty_q;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        full_d   = count_d == CW'(DEPTH);
        empty_d  = count_d == '0;
    end
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end
    assign rd_data = mem_q[rd_ptr_q];
    assign full    = full_q;
    assign empty   = empty_q;
    assign count   = count_q;
endmodule

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: host byte queue feeding a UART transmitter; UART_TXQ_OVERFLOW_EN enables the sticky overflow flag
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = UART_DATA_W
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     ovf_clr,
    input  logic                     tx_busy,
    output logic                     send,
    output logic [DATA_W-1:0]        send_data
);
    txq_state_e state_q, state_d;
    logic send_q, send_d, pop, ovf_q, ovf_d;
    logic [DATA_W-1:0] send_data_q, send_data_d, rd_data;
    uart_sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
        .clk(clk), .rstn(rstn), .push(wr_en), .wr_data(wr_data), .pop(pop),
        .rd_data(rd_data), .full(full), .empty(empty), .count(count)
    );
    // The pop and the send strobe are produced together on the IDLE->LAUNCH edge
    always_comb begin
        state_d     = state_q;
        send_d      = 1'b0;
        send_data_d = send_data_q;
        pop         = 1'b0;
        unique case (state_q)
            IDLE: if (!empty && !tx_busy) begin
                state_d     = LAUNCH;
                send_d      = 1'b1;
                send_data_d = rd_data;
                pop         = 1'b1;
            end
            LAUNCH:    state_d = WAIT_BUSY;
            WAIT_BUSY: state_d = tx_busy ? WAIT_DONE : WAIT_BUSY;
            WAIT_DONE: state_d = tx_busy ? WAIT_DONE : IDLE;
            default:   state_d = IDLE;
        endcase
    end
`ifdef UART_TXQ_OVERFLOW_EN
    assign ovf_d = (wr_en && full) ? 1'b1 : ovf_clr ? 1'b0 : ovf_q;
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
    assign ovf_d = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            send_q      <= 1'b0;
            send_data_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            send_q      <= send_d;
            send_data_q <= send_data_d;
            ovf_q       <= ovf_d;
        end
    end
    assign send      = send_q;
    assign send_data = send_data_q;
    assign overflow  = ovf_q;
endmodule
